sample_conditioner: RTL and testbench
=====================================

Name: sample_conditioner

Overview:
- Parametrised microphone front-end that sits between the I2S receiver and the pitch-detection, PDM and UART consumers.
- Takes raw signed I2S words and applies optional DC removal.
- Applies a runtime-selectable power-of-two gain with signed saturation, replacing plain bit-slice truncation.
- Emits fixed-width samples plus a clip indicator, a saturating clip counter and a peak-hold level meter for display.

Parameters:
- IN_WIDTH, 24, width of raw signed input word.
- OUT_WIDTH, 16, width of signed output sample; must be < IN_WIDTH.
- MAX_SHIFT, 7, largest legal left-shift (gain) value.
- DC_SHIFT, 10, DC-tracking filter time constant; estimate = acc >>> DC_SHIFT.
- PEAK_HOLD, 48000, number of output samples a peak is held before it may fall.
- CNT_WIDTH, 16, width of the clip counter.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- data_in  input  IN_WIDTH  raw signed sample
- valid_in  input  1  data_in valid; may be high every cycle
- shift_in  input  $clog2(MAX_SHIFT+1)  gain shift, sampled with valid_in
- dc_en_in  input  1  enable DC removal
- clear_in  input  1  one-cycle pulse; clears clip counter and peak
- data_out  output  OUT_WIDTH  conditioned signed sample
- valid_out  output  1  data_out valid, one-cycle pulse per sample
- clip_out  output  1  high with valid_out when data_out was saturated
- clip_count_out  output  CNT_WIDTH  saturating count of clipped samples
- peak_out  output  OUT_WIDTH-1  peak-hold magnitude of data_out

Behaviour:
- Reset:
  - Asynchronous on rst_n_in low.
  - All outputs go to 0, and so do the DC accumulator, hold counter and all pipeline valids.
  - In-flight samples are discarded; nothing is emitted after release for pre-reset inputs.
- Pipeline: fixed 3-cycle latency, valid_in at cycle N -> valid_out at N+3. Full throughput, no backpressure.
- S1 (capture): register sign-extended data_in and shift_in. A shift_in greater than MAX_SHIFT is clamped to MAX_SHIFT. Each sample carries its own shift, so shift changes mid-stream affect only new samples.
- S2 (DC removal):
  - acc is a signed accumulator of width IN_WIDTH+DC_SHIFT+1.
  - If dc_en_in: est = acc >>> DC_SHIFT; y = x - est; acc <= acc + y on each valid sample.
  - If !dc_en_in: y = x and acc <= 0.
  - y is IN_WIDTH+1 bits signed.
  - dc_en_in is sampled at S2 time.
- S3 (gain/saturate):
  - z = (y <<< shift) >>> (IN_WIDTH-OUT_WIDTH), computed at full width with no intermediate loss.
  - If z > 2^(OUT_WIDTH-1)-1, output 0x7FFF.
  - If z < -2^(OUT_WIDTH-1), output 0x8000.
  - In either saturating case clip_out = 1 for that sample.
  - With shift = 0 and DC off, data_out = data_in[IN_WIDTH-1 -: OUT_WIDTH] exactly.
- Outputs are registered. data_out and clip_out hold between valid_out pulses.
- Clip counter: +1 per clipped output and saturates at all-ones. clear_in has priority over a simultaneous increment, so the result is 0.
- Peak meter, per valid_out with m = |data_out| (|0x8000| -> 0x7FFF):
  - If m >= peak: peak <= m, hold <= 0.
  - Else if hold == PEAK_HOLD-1: peak <= m, hold <= 0.
  - Else hold <= hold+1.
  - clear_in sets peak and hold to 0 and wins over a simultaneous update.

Test Plan:
- DC off, shift 0, data_in 0x123456 at cycle 0 -> valid_out at cycle 3, data_out 0x1234, clip_out 0.
- Shift 4, data_in 0x001234 -> 0x0123; then data_in 0x100000 -> data_out 0x7FFF, clip_out 1, clip_count_out 1.
- Shift 4, data_in 0xF00000 -> data_out 0x8000, clip_out 1. Then shift_in 15 -> treated as shift 7.
- dc_en 1, constant data_in 0x010000 for 2^DC_SHIFT*16 samples -> first output 0x0100, monotonic decay, final |data_out| <= 1. Deassert dc_en -> output returns to 0x0100.
- Peak, PEAK_HOLD=4: outputs 0x4000, 0x0100, 0x0100, 0x0100, 0x0100 -> peak_out 0x4000 through the third 0x0100 and 0x0100 after the fourth. clear_in together with a clip -> clip_count_out 0, peak_out 0.
- Back-to-back valid_in for 8 cycles with changing shift -> 8 consecutive valid_out pulses, each using its own shift. Pull rst_n_in low mid-burst -> outputs 0 immediately, no valid_out after release.

Source files
------------

// File: rtl/sample_conditioner.sv
// Microphone front-end: capture, optional DC removal, power-of-two gain with
// signed saturation, clip counter and peak-hold level meter. Latency 3 cycles.
module sample_conditioner #(
    parameter int unsigned IN_WIDTH  = 24,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned MAX_SHIFT = 7,
    parameter int unsigned DC_SHIFT  = 10,
    parameter int unsigned PEAK_HOLD = 48000,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic [IN_WIDTH-1:0]              data_in,
    input  logic                             valid_in,
    input  logic [$clog2(MAX_SHIFT+1)-1:0]   shift_in,
    input  logic                             dc_en_in,
    input  logic                             clear_in,
    output logic [OUT_WIDTH-1:0]             data_out,
    output logic                             valid_out,
    output logic                             clip_out,
    output logic [CNT_WIDTH-1:0]             clip_count_out,
    output logic [OUT_WIDTH-2:0]             peak_out
);

    localparam int unsigned SHW  = $clog2(MAX_SHIFT + 1);
    localparam int unsigned YW   = IN_WIDTH + 1;
    localparam int unsigned AW   = IN_WIDTH + DC_SHIFT + 1;
    localparam int unsigned ZW   = YW + MAX_SHIFT;
    localparam int unsigned DROP = IN_WIDTH - OUT_WIDTH;
    localparam int unsigned PW   = OUT_WIDTH - 1;
    localparam int unsigned HW   = $clog2(PEAK_HOLD + 1);

    localparam logic signed [ZW-1:0] Z_MAX = ZW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ZW-1:0] Z_MIN = ~Z_MAX;

    // S1: capture with sign extension and gain clamp
    logic signed [YW-1:0]  x1;
    logic [SHW-1:0]        sh1;
    logic                  v1;
    logic [SHW-1:0]        sh_c;

    always_comb begin
        sh_c = shift_in;
        if (shift_in > SHW'(MAX_SHIFT)) begin
            sh_c = SHW'(MAX_SHIFT);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x1  <= '0;
            sh1 <= '0;
            v1  <= 1'b0;
        end else begin
            v1 <= valid_in;
            if (valid_in) begin
                x1  <= {data_in[IN_WIDTH-1], data_in};
                sh1 <= sh_c;
            end
        end
    end

    // S2: leaky DC tracker, estimate is the accumulator scaled down by DC_SHIFT
    logic signed [AW-1:0]  acc;
    logic signed [YW-1:0]  est_c;
    logic signed [YW-1:0]  y_c;
    logic signed [YW-1:0]  y2;
    logic [SHW-1:0]        sh2;
    logic                  v2;

    always_comb begin
        est_c = YW'(acc >>> DC_SHIFT);
        y_c   = x1;
        if (dc_en_in) begin
            y_c = x1 - est_c;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc <= '0;
            y2  <= '0;
            sh2 <= '0;
            v2  <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                y2  <= y_c;
                sh2 <= sh1;
            end
            if (!dc_en_in) begin
                acc <= '0;
            end else if (v1) begin
                acc <= acc + {{DC_SHIFT{y_c[YW-1]}}, y_c};
            end
        end
    end

    // S3: gain at full width, then saturate into the output range
    logic signed [ZW-1:0]  y_ext_c;
    logic signed [ZW-1:0]  z_c;
    logic [OUT_WIDTH-1:0]  sample_c;
    logic                  clip_c;
    logic [PW-1:0]         mag_c;

    always_comb begin
        y_ext_c  = {{MAX_SHIFT{y2[YW-1]}}, y2};
        z_c      = (y_ext_c <<< sh2) >>> DROP;
        sample_c = z_c[OUT_WIDTH-1:0];
        clip_c   = 1'b0;
        if (z_c > Z_MAX) begin
            sample_c = {1'b0, {PW{1'b1}}};
            clip_c   = 1'b1;
        end else if (z_c < Z_MIN) begin
            sample_c = {1'b1, {PW{1'b0}}};
            clip_c   = 1'b1;
        end
        // most negative code reports full-scale magnitude
        mag_c = sample_c[PW-1:0];
        if (sample_c[OUT_WIDTH-1]) begin
            if (sample_c[PW-1:0] == '0) begin
                mag_c = '1;
            end else begin
                mag_c = PW'(-sample_c);
            end
        end
    end

    logic [HW-1:0] hold;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_out       <= '0;
            valid_out      <= 1'b0;
            clip_out       <= 1'b0;
            clip_count_out <= '0;
            peak_out       <= '0;
            hold           <= '0;
        end else begin
            valid_out <= v2;
            if (v2) begin
                data_out <= sample_c;
                clip_out <= clip_c;
            end
            // clear overrides any same-cycle counter or meter update
            if (clear_in) begin
                clip_count_out <= '0;
                peak_out       <= '0;
                hold           <= '0;
            end else if (v2) begin
                if (clip_c && (clip_count_out != '1)) begin
                    clip_count_out <= clip_count_out + CNT_WIDTH'(1);
                end
                if (mag_c >= peak_out) begin
                    peak_out <= mag_c;
                    hold     <= '0;
                end else if (hold == HW'(PEAK_HOLD - 1)) begin
                    peak_out <= mag_c;
                    hold     <= '0;
                end else begin
                    hold <= hold + HW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sample_conditioner.sv
// Bench for sample_conditioner: arithmetic reference model checked every cycle,
// plus directed literal expectations and randomized traffic.
module tb_sample_conditioner;

    localparam int IW = 24;
    localparam int OW = 16;
    localparam int MS = 5;
    localparam int DS = 10;
    localparam int PH = 4;
    localparam int CW = 16;
    localparam int SW = 3;

    logic          clk_in   = 1'b0;
    logic          rst_n_in = 1'b0;
    logic [IW-1:0] data_in  = '0;
    logic          valid_in = 1'b0;
    logic [SW-1:0] shift_in = '0;
    logic          dc_en_in = 1'b0;
    logic          clear_in = 1'b0;
    logic [OW-1:0] data_out;
    logic          valid_out;
    logic          clip_out;
    logic [CW-1:0] clip_count_out;
    logic [OW-2:0] peak_out;

    sample_conditioner #(
        .IN_WIDTH (IW), .OUT_WIDTH(OW), .MAX_SHIFT(MS),
        .DC_SHIFT (DS), .PEAK_HOLD(PH), .CNT_WIDTH(CW)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .data_in       (data_in),
        .valid_in      (valid_in),
        .shift_in      (shift_in),
        .dc_en_in      (dc_en_in),
        .clear_in      (clear_in),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .clip_out      (clip_out),
        .clip_count_out(clip_count_out),
        .peak_out      (peak_out)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: samples in flight as (value, shift) pairs, a DC
    // accumulator, and the expected registered outputs.
    bit            cap_v = 1'b0;
    longint        cap_x = 0;
    int            cap_sh = 0;
    bit            ys_v = 1'b0;
    longint        ys_y = 0;
    int            ys_sh = 0;
    longint        acc_m = 0;
    bit            e_valid = 1'b0;
    logic [OW-1:0] e_data = '0;
    bit            e_clip = 1'b0;
    logic [CW-1:0] e_cnt = '0;
    logic [OW-2:0] e_peak = '0;
    int            e_hold = 0;

    task automatic model_step();
        longint z;
        longint sd;
        longint maxv;
        logic [OW-1:0] d;
        bit c;
        logic [OW-2:0] m;
        if (!rst_n_in) begin
            cap_v = 0; ys_v = 0; acc_m = 0;
            e_valid = 0; e_data = '0; e_clip = 0; e_cnt = '0; e_peak = '0; e_hold = 0;
            return;
        end
        maxv = (longint'(1) <<< (OW - 1)) - 1;
        d = '0; c = 0; m = '0;
        e_valid = ys_v;
        if (ys_v) begin
            z = (ys_y <<< ys_sh) >>> (IW - OW);
            if (z > maxv) begin
                d = OW'(maxv); c = 1;
            end else if (z < -maxv - 1) begin
                d = OW'(-maxv - 1); c = 1;
            end else begin
                d = OW'(z);
            end
            e_data = d;
            e_clip = c;
            sd = longint'($signed(d));
            if (sd < 0) sd = -sd;
            if (sd > maxv) sd = maxv;
            m = (OW - 1)'(sd);
        end
        if (clear_in) begin
            e_cnt = '0; e_peak = '0; e_hold = 0;
        end else if (ys_v) begin
            if (c && e_cnt != '1) e_cnt = e_cnt + 1'b1;
            if (m >= e_peak) begin
                e_peak = m; e_hold = 0;
            end else if (e_hold == PH - 1) begin
                e_peak = m; e_hold = 0;
            end else begin
                e_hold++;
            end
        end
        ys_v = cap_v;
        if (cap_v) begin
            ys_y  = dc_en_in ? cap_x - (acc_m >>> DS) : cap_x;
            ys_sh = cap_sh;
        end
        if (!dc_en_in) acc_m = 0;
        else if (cap_v) acc_m = acc_m + ys_y;
        cap_v = valid_in;
        if (valid_in) begin
            cap_x  = longint'($signed(data_in));
            cap_sh = (int'(shift_in) > MS) ? MS : int'(shift_in);
        end
    endtask

    initial forever begin
        @(posedge clk_in or negedge rst_n_in);
        model_step();
    end

    bit chk_en = 1'b0;

    initial forever begin
        @(negedge clk_in);
        if (chk_en) begin
            check("valid_out", longint'(valid_out), longint'(e_valid));
            check("data_out", longint'(data_out), longint'(e_data));
            check("clip_out", longint'(clip_out), longint'(e_clip));
            check("clip_count_out", longint'(clip_count_out), longint'(e_cnt));
            check("peak_out", longint'(peak_out), longint'(e_peak));
        end
    end

    // One isolated sample; checks latency and the literal result.
    task automatic send_expect(input string name, input logic [IW-1:0] d, input logic [SW-1:0] s,
                               input logic [OW-1:0] exp_d, input bit exp_c);
        int lat;
        @(negedge clk_in);
        data_in = d; shift_in = s; valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        lat = 1;
        while (!valid_out && lat < 8) begin
            @(negedge clk_in);
            lat++;
        end
        check({name, "_latency"}, longint'(lat), 3);
        check({name, "_data"}, longint'(data_out), longint'(exp_d));
        check({name, "_clip"}, longint'(clip_out), longint'(exp_c));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        int nout;
        int viol;
        bit first;
        longint sd;
        longint prev;
        logic [IW-1:0] dat [5];
        logic [OW-2:0] pk [5];

        // reset state
        repeat (3) @(negedge clk_in);
        check("rst_data", longint'(data_out), 0);
        check("rst_valid", longint'(valid_out), 0);
        check("rst_clip", longint'(clip_out), 0);
        check("rst_count", longint'(clip_count_out), 0);
        check("rst_peak", longint'(peak_out), 0);
        chk_en = 1'b1;
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // plain slice, gain, saturation both ways, shift clamp
        send_expect("t1", 24'h123456, 3'd0, 16'h1234, 1'b0);
        send_expect("t2a", 24'h001234, 3'd4, 16'h0123, 1'b0);
        send_expect("t2b", 24'h100000, 3'd4, 16'h7FFF, 1'b1);
        check("t2_count", longint'(clip_count_out), 1);
        send_expect("t3a", 24'hF00000, 3'd4, 16'h8000, 1'b1);
        check("t3_count", longint'(clip_count_out), 2);
        send_expect("t3_clamp", 24'h000100, 3'd7, 16'h0020, 1'b0);

        // DC removal on a constant input
        @(negedge clk_in);
        dc_en_in = 1'b1; data_in = 24'h010000; shift_in = '0; valid_in = 1'b1;
        first = 1; viol = 0; prev = 0; nout = 0;
        for (int i = 0; i < 16384 + 4; i++) begin
            @(negedge clk_in);
            if (i == 16383) valid_in = 1'b0;
            if (valid_out) begin
                sd = longint'($signed(data_out));
                if (first) check("dc_first", sd, 16'h0100);
                else if (sd > prev) viol++;
                prev = sd;
                first = 0;
                nout++;
            end
        end
        check("dc_count", longint'(nout), 16384);
        check("dc_monotonic_violations", longint'(viol), 0);
        check("dc_final_small", longint'(prev >= -1 && prev <= 1), 1);
        dc_en_in = 1'b0;
        send_expect("dc_off", 24'h010000, 3'd0, 16'h0100, 1'b0);

        // peak hold with PEAK_HOLD = 4
        @(negedge clk_in);
        clear_in = 1'b1;
        @(negedge clk_in);
        clear_in = 1'b0;
        check("clear_peak", longint'(peak_out), 0);
        check("clear_count", longint'(clip_count_out), 0);
        dat[0] = 24'h400000;
        for (int i = 1; i < 5; i++) dat[i] = 24'h010000;
        pk[0] = 15'h4000; pk[1] = 15'h4000; pk[2] = 15'h4000; pk[3] = 15'h4000; pk[4] = 15'h0100;
        k = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk_in);
            if (valid_out) begin
                if (k < 5) check($sformatf("peak_%0d", k), longint'(peak_out), longint'(pk[k]));
                k++;
            end
            valid_in = (j < 5);
            if (j < 5) begin
                data_in = dat[j]; shift_in = '0;
            end
        end
        check("peak_samples", longint'(k), 5);

        // clear coincident with a clipped output
        k = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk_in);
            if (valid_out) begin
                check("clrclip_clip", longint'(clip_out), 1);
                check("clrclip_count", longint'(clip_count_out), 0);
                check("clrclip_peak", longint'(peak_out), 0);
                k++;
            end
            valid_in = (j == 0);
            data_in = 24'h7FFFFF; shift_in = 3'd5;
            clear_in = (j == 2);
        end
        check("clrclip_samples", longint'(k), 1);

        // back-to-back burst with per-sample shifts
        k = 0;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk_in);
            if (valid_out) k++;
            valid_in = (j < 8);
            data_in = IW'($urandom);
            shift_in = SW'(j % 6);
        end
        check("burst_pulses", longint'(k), 8);

        // asynchronous reset in the middle of a burst
        for (int j = 0; j < 6; j++) begin
            @(negedge clk_in);
            valid_in = 1'b1;
            data_in = IW'($urandom);
            shift_in = SW'($urandom_range(0, 7));
        end
        #2;
        rst_n_in = 1'b0;
        valid_in = 1'b0;
        #1;
        check("arst_data", longint'(data_out), 0);
        check("arst_valid", longint'(valid_out), 0);
        check("arst_clip", longint'(clip_out), 0);
        check("arst_count", longint'(clip_count_out), 0);
        check("arst_peak", longint'(peak_out), 0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        k = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk_in);
            if (valid_out) k++;
        end
        check("arst_no_valid", longint'(k), 0);

        // randomized traffic
        for (int j = 0; j < 3000; j++) begin
            @(negedge clk_in);
            valid_in = ($urandom_range(0, 3) != 0);
            data_in  = IW'($urandom);
            shift_in = SW'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) dc_en_in = ~dc_en_in;
            clear_in = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk_in);
        valid_in = 1'b0;
        clear_in = 1'b0;
        repeat (5) @(negedge clk_in);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
